// File: rtl/ahb_slave_regmem.sv
// AHB-Lite responder over a small word-addressed register memory.
// Programmable OKAY wait states; bad size/alignment/range gets the two-cycle ERROR response.
module ahb_slave_regmem #(
    parameter int C_S_AHB_DATA_WIDTH = 32,
    parameter int C_S_AHB_ADDR_WIDTH = 32,
    parameter int C_S_MEM_ADDR_WIDTH = 4,
    parameter logic [C_S_AHB_ADDR_WIDTH-1:0] C_S_BASE_ADDR = '0,
    parameter int C_S_WAIT_STATES = 0
) (
    input  logic                          S_HCLK,
    input  logic                          S_REST,
    input  logic                          S_HSEL,
    input  logic [C_S_AHB_ADDR_WIDTH-1:0] S_HADDR,
    input  logic                          S_HWRITE,
    input  logic [1:0]                    S_HTRANS,
    input  logic [2:0]                    S_HBURST,
    input  logic [2:0]                    S_HSIZE,
    input  logic [3:0]                    S_HPORT,
    input  logic                          S_HREADY,
    input  logic [C_S_AHB_DATA_WIDTH-1:0] S_HWDATA,
    output logic [C_S_AHB_DATA_WIDTH-1:0] S_HRDATA,
    output logic                          S_HREADY_OUT,
    output logic [1:0]                    S_HRESP
);
    localparam int AW    = C_S_AHB_ADDR_WIDTH;
    localparam int MAW   = C_S_MEM_ADDR_WIDTH;
    localparam int DW    = C_S_AHB_DATA_WIDTH;
    localparam int DEPTH = 2**MAW;
    localparam logic [3:0] WS_RELOAD = (C_S_WAIT_STATES > 0) ? 4'(C_S_WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    typedef struct packed {
        logic           vld;
        logic           write;
        logic [MAW-1:0] idx;
        logic [3:0]     be;
    } pend_t;

    state_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    pend_t          pend, pend_nxt;
    logic [DW-1:0]  mem [DEPTH];

    logic [AW-1:0]  offset;
    logic [3:0]     be_dec;
    logic           capture, bad_range, bad_size, bad_align, err, done;
    logic           unused_ctl;

    assign unused_ctl = ^{S_HBURST, S_HPORT};

    assign offset    = S_HADDR - C_S_BASE_ADDR;
    assign capture   = S_HSEL & S_HREADY & S_HTRANS[1] & (state == ST_IDLE || state == ST_ERR2);
    // Addresses below the base wrap to a huge offset and land here too.
    assign bad_range = |offset[AW-1:MAW+2];
    assign bad_size  = S_HSIZE > 3'b010;
    assign bad_align = (S_HSIZE == 3'b001 && offset[0]) ||
                       (S_HSIZE == 3'b010 && offset[1:0] != 2'b00);
    assign err       = bad_range | bad_size | bad_align;

    always_comb begin
        be_dec = 4'b0000;
        case (S_HSIZE[1:0])
            2'b00:   be_dec[offset[1:0]] = 1'b1;
            2'b01:   be_dec = offset[1] ? 4'b1100 : 4'b0011;
            default: be_dec = 4'b1111;
        endcase
    end

    // An OKAY data phase finishes whenever IDLE holds a pending transfer.
    assign done = (state == ST_IDLE) & pend.vld;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        if (done)
            pend_nxt.vld = 1'b0;
        case (state)
            ST_WAIT: begin
                if (cnt == 4'd0) state_nxt = ST_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
        if (capture) begin
            pend_nxt.vld   = ~err;
            pend_nxt.write = S_HWRITE;
            pend_nxt.idx   = offset[MAW+1:2];
            pend_nxt.be    = be_dec;
            if (err) begin
                state_nxt = ST_ERR1;
            end else if (C_S_WAIT_STATES > 0) begin
                state_nxt = ST_WAIT;
                cnt_nxt   = WS_RELOAD;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge S_HCLK or posedge S_REST) begin
        if (S_REST) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    always_ff @(posedge S_HCLK or posedge S_REST) begin
        if (S_REST) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (done && pend.write) begin
            for (int l = 0; l < 4; l++)
                if (pend.be[l])
                    mem[pend.idx][8*l +: 8] <= S_HWDATA[8*l +: 8];
        end
    end

    assign S_HREADY_OUT = (state == ST_IDLE) || (state == ST_ERR2);
    assign S_HRESP      = (state == ST_ERR1 || state == ST_ERR2) ? 2'b01 : 2'b00;
    assign S_HRDATA     = (done && !pend.write) ? mem[pend.idx] : '0;

endmodule

// File: tb/tb_ahb_slave_regmem.sv
// Bench for ahb_slave_regmem: three instances (0/2/3 wait states) driven by one pipelined
// master, checked against an array memory model and a table of directed vectors.
module tb_ahb_slave_regmem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2:0]      hsel;
    logic [31:0]     haddr, hwdata;
    logic            hwrite;
    logic [1:0]      htrans;
    logic [2:0]      hburst, hsize;
    logic [3:0]      hprot;
    logic [2:0][31:0] hrdata;
    logic [2:0]      hready_o;
    logic [2:0][1:0] hresp;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_slave_regmem #(.C_S_WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
            .S_HCLK(clk), .S_REST(rst), .S_HSEL(hsel[g]), .S_HADDR(haddr),
            .S_HWRITE(hwrite), .S_HTRANS(htrans), .S_HBURST(hburst), .S_HSIZE(hsize),
            .S_HPORT(hprot), .S_HREADY(hready_o[g]), .S_HWDATA(hwdata),
            .S_HRDATA(hrdata[g]), .S_HREADY_OUT(hready_o[g]), .S_HRESP(hresp[g])
        );
    end

    typedef struct {
        bit          sel;
        bit [1:0]    trans;
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    txn_t        txq[$];
    logic [31:0] rd_log[$];
    logic [31:0] mem_m [3][16];
    vec_t        vt[17];
    int          cur;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] last_rdata;
    logic [1:0]  last_resp;
    int          last_stalls;

    function automatic int ws_of(int d);
        return d == 0 ? 0 : (d == 1 ? 2 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut %0d): got %h expected %h", name, cur, act, exp);
        end
    endtask

    // Window is 16 words at base 0; a transfer must be naturally aligned and at most a word.
    function automatic bit m_err(input logic [31:0] a, input logic [2:0] s);
        if (a >= 32'h40) return 1'b1;
        if (s > 3'd2) return 1'b1;
        return (a % (32'd1 << s)) != 32'd0;
    endfunction

    function automatic void m_write(input int d, input logic [31:0] a, input logic [2:0] s,
                                    input logic [31:0] wd);
        int lo, n;
        lo = int'(a[1:0]);
        n  = 1 << s;
        for (int b = 0; b < 4; b++)
            if (b >= lo && b < lo + n)
                mem_m[d][a[5:2]][8*b +: 8] = wd[8*b +: 8];
    endfunction

    task automatic drive_idle();
        hsel = 3'b000; haddr = '0; hwrite = 1'b0; htrans = 2'b00;
        hsize = 3'b000; hburst = 3'b000; hprot = 4'h0;
    endtask

    task automatic drive_ap(input txn_t t);
        hsel = 3'b000;
        if (t.sel) hsel[cur] = 1'b1;
        haddr = t.addr; hwrite = t.write; htrans = t.trans;
        hsize = t.size; hburst = t.burst; hprot = 4'h3;
    endtask

    task automatic push(input bit w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, input bit [1:0] tr, input logic [2:0] bu);
        txn_t t;
        t.sel = 1'b1; t.trans = tr; t.write = w; t.addr = a;
        t.size = s; t.burst = bu; t.wdata = d;
        txq.push_back(t);
    endtask

    function automatic txn_t rnd_txn();
        txn_t t;
        int   r;
        t.sel   = ($urandom_range(0, 9) != 0);
        r       = $urandom_range(0, 9);
        t.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        t.write = 1'($urandom_range(0, 1));
        t.burst = 3'($urandom_range(0, 7));
        t.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        if ($urandom_range(0, 7) == 0) begin
            t.addr = 32'($urandom_range(0, 127));
        end else begin
            t.addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if (t.size == 3'd0)      t.addr[1:0] = 2'($urandom_range(0, 3));
            else if (t.size == 3'd1) t.addr[1]   = 1'($urandom_range(0, 1));
        end
        t.wdata = $urandom();
        return t;
    endfunction

    // Pipelined master: address phase of txq[i] overlaps data phase of the previous transfer.
    task automatic run_txq();
        txn_t        dp;
        bit          dp_v, act, er;
        int          i, stalls, guard;
        logic [31:0] exp_rd;
        dp_v = 1'b0; i = 0; stalls = 0; guard = 0;
        while ((i < txq.size() || dp_v) && guard < 500) begin
            if (i < txq.size()) drive_ap(txq[i]);
            else                drive_idle();
            hwdata = (dp_v && dp.write) ? dp.wdata : $urandom();
            @(negedge clk);
            if (dp_v) begin
                act = dp.sel && dp.trans[1];
                er  = act && m_err(dp.addr, dp.size);
                if (!hready_o[cur]) begin
                    stalls++;
                    chk("stall_resp", 32'(hresp[cur]), 32'(er));
                    chk("stall_rdata", hrdata[cur], 32'd0);
                end else begin
                    exp_rd = (act && !er && !dp.write) ? mem_m[cur][dp.addr[5:2]] : 32'd0;
                    chk("stall_count", 32'(stalls), 32'(!act ? 0 : (er ? 1 : ws_of(cur))));
                    chk("resp", 32'(hresp[cur]), 32'(er));
                    chk("rdata", hrdata[cur], exp_rd);
                    if (act && !er && dp.write)  m_write(cur, dp.addr, dp.size, dp.wdata);
                    if (act && !er && !dp.write) rd_log.push_back(hrdata[cur]);
                    last_rdata  = hrdata[cur];
                    last_resp   = hresp[cur];
                    last_stalls = stalls;
                    dp_v = 1'b0;
                end
            end
            if (hready_o[cur]) begin
                if (i < txq.size()) begin
                    dp = txq[i]; dp_v = 1'b1; i++;
                end
                stalls = 0;
            end
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 500) chk("transfer_timeout", 32'(guard), 32'd0);
        txq.delete();
        drive_idle();
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 16; w++)
                mem_m[d][w] = 32'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{1'b1, 32'h04, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h04, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 32'h04, 3'd2, 32'h11223344, 1'b0, 32'h0};
        vt[3]  = '{1'b1, 32'h05, 3'd0, 32'h0000AB00, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'h04, 3'd2, 32'h0,        1'b0, 32'h1122AB44};
        vt[5]  = '{1'b0, 32'h40, 3'd2, 32'h0,        1'b1, 32'h0};
        vt[6]  = '{1'b1, 32'h03, 3'd1, 32'hFFFFFFFF, 1'b1, 32'h0};
        vt[7]  = '{1'b1, 32'h40, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0};
        vt[8]  = '{1'b0, 32'h00, 3'd2, 32'h0,        1'b0, 32'h0};
        vt[9]  = '{1'b0, 32'h04, 3'd3, 32'h0,        1'b1, 32'h0};
        vt[10] = '{1'b1, 32'h06, 3'd1, 32'hCAFE0000, 1'b0, 32'h0};
        vt[11] = '{1'b0, 32'h04, 3'd2, 32'h0,        1'b0, 32'hCAFEAB44};
        vt[12] = '{1'b1, 32'h02, 3'd2, 32'h5A5A5A5A, 1'b1, 32'h0};
        vt[13] = '{1'b0, 32'h00, 3'd0, 32'h0,        1'b0, 32'h0};
        vt[14] = '{1'b1, 32'h3F, 3'd0, 32'h77000000, 1'b0, 32'h0};
        vt[15] = '{1'b0, 32'h3C, 3'd2, 32'h0,        1'b0, 32'h77000000};
        vt[16] = '{1'b0, 32'h05, 3'd0, 32'h0,        1'b0, 32'hCAFEAB44};

        rst = 1'b1; hwdata = '0; cur = 0;
        drive_idle();
        clear_model();
        #1;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            chk("reset_hready", 32'(hready_o[d]), 32'd1);
            chk("reset_hresp", 32'(hresp[d]), 32'd0);
            chk("reset_hrdata", hrdata[d], 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait write then read of the same word, back to back.
        cur = 0;
        push(1'b1, 32'h8, 3'd2, 32'hDEADBEEF, 2'b10, 3'd0);
        push(1'b0, 32'h8, 3'd2, 32'h0, 2'b10, 3'd0);
        run_txq();
        chk("wr_rd_b2b_data", last_rdata, 32'hDEADBEEF);
        chk("wr_rd_b2b_stalls", 32'(last_stalls), 32'd0);

        for (int k = 0; k < 17; k++) begin
            push(vt[k].write, vt[k].addr, vt[k].size, vt[k].wdata, 2'b10, 3'd0);
            run_txq();
            chk($sformatf("tbl%0d_resp", k), 32'(last_resp), 32'(vt[k].exp_err));
            if (!vt[k].write && !vt[k].exp_err)
                chk($sformatf("tbl%0d_rdata", k), last_rdata, vt[k].exp_rdata);
        end

        // INCR4 write with a BUSY slot, then INCR4 read.
        rd_log.delete();
        push(1'b1, 32'h0, 3'd2, 32'hA0, 2'b10, 3'd3);
        push(1'b1, 32'h4, 3'd2, 32'hA1, 2'b11, 3'd3);
        push(1'b1, 32'h8, 3'd2, 32'hBAD0BAD0, 2'b01, 3'd3);
        push(1'b1, 32'h8, 3'd2, 32'hA2, 2'b11, 3'd3);
        push(1'b1, 32'hC, 3'd2, 32'hA3, 2'b11, 3'd3);
        push(1'b0, 32'h0, 3'd2, 32'h0, 2'b10, 3'd3);
        push(1'b0, 32'h4, 3'd2, 32'h0, 2'b11, 3'd3);
        push(1'b0, 32'h8, 3'd2, 32'h0, 2'b11, 3'd3);
        push(1'b0, 32'hC, 3'd2, 32'h0, 2'b11, 3'd3);
        run_txq();
        chk("incr4_nreads", 32'(rd_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < rd_log.size(); k++)
            chk($sformatf("incr4_rd%0d", k), rd_log[k], 32'hA0 + 32'(k));

        // Two wait states: read of 0x8 stalls twice, then completes.
        cur = 1;
        push(1'b1, 32'h8, 3'd2, 32'h12345678, 2'b10, 3'd0);
        run_txq();
        push(1'b0, 32'h8, 3'd2, 32'h0, 2'b10, 3'd0);
        run_txq();
        chk("ws2_stalls", 32'(last_stalls), 32'd2);
        chk("ws2_rdata", last_rdata, 32'h12345678);

        for (int d = 0; d < 3; d++) begin
            cur = d;
            for (int n = 0; n < 60; n++) txq.push_back(rnd_txn());
            run_txq();
            for (int w = 0; w < 16; w++) push(1'b0, 32'(w * 4), 3'd2, 32'h0, 2'b10, 3'd1);
            run_txq();
        end

        // Reset during the second wait cycle of a write on the 3-wait instance.
        cur = 2;
        push(1'b1, 32'h10, 3'd2, 32'h55AA55AA, 2'b10, 3'd0);
        push(1'b0, 32'h10, 3'd2, 32'h0, 2'b10, 3'd0);
        run_txq();
        chk("pre_reset_rdata", last_rdata, 32'h55AA55AA);
        push(1'b1, 32'h10, 3'd2, 32'hBADBAD00, 2'b10, 3'd0);
        drive_ap(txq[0]);
        txq.delete();
        @(posedge clk); #1;
        drive_idle();
        hwdata = 32'hBADBAD00;
        @(negedge clk);
        chk("wait1_hready", 32'(hready_o[2]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait2_hready", 32'(hready_o[2]), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_hready", 32'(hready_o[2]), 32'd1);
        chk("async_rst_hresp", 32'(hresp[2]), 32'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        push(1'b0, 32'h10, 3'd2, 32'h0, 2'b10, 3'd0);
        run_txq();
        chk("post_reset_rdata", last_rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
